// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the pipelined MIPS control unit.
// Holds the opcode encodings, the bundle widths, the bit position of each
// control field inside its bundle, and the all-zero bubble values.
package ctrl_pkg;

  localparam int OPCODE_BITS = 6;
  localparam int REG_BITS    = 5;
  localparam int EX_BITS     = 4;
  localparam int M_BITS      = 3;
  localparam int WB_BITS     = 2;

  // Recognised instruction classes
  typedef enum logic [OPCODE_BITS-1:0] {
    RTYPE = 6'b000000,
    LW    = 6'b100011,
    SW    = 6'b101011,
    BEQ   = 6'b000100,
    NOP   = 6'b100000
  } opcode_e;

  // EX bundle {RegDst, ALUOp1, ALUOp0, ALUSrc}
  localparam int REGDST_IDX   = 3;
  localparam int ALUOP1_IDX   = 2;
  localparam int ALUOP0_IDX   = 1;
  localparam int ALUSRC_IDX   = 0;

  // M bundle {Branch, MemRead, MemWrite}
  localparam int BRANCH_IDX   = 2;
  localparam int MEMREAD_IDX  = 1;
  localparam int MEMWRITE_IDX = 0;

  // WB bundle {RegWrite, MemtoReg}
  localparam int REGWRITE_IDX = 1;
  localparam int MEMTOREG_IDX = 0;

  // Bubble values: a stage holding these does nothing architecturally visible
  localparam logic [EX_BITS-1:0] BUBBLE_EX = '0;
  localparam logic [M_BITS-1:0]  BUBBLE_M  = '0;
  localparam logic [WB_BITS-1:0] BUBBLE_WB = '0;

  // Full control word carried from ID into the ID/EX register
  typedef struct packed {
    logic [EX_BITS-1:0] ex;
    logic [M_BITS-1:0]  m;
    logic [WB_BITS-1:0] wb;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '{ex: BUBBLE_EX, m: BUBBLE_M, wb: BUBBLE_WB};

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> {EX, M, WB} control table.
// o_valid is high only for recognised opcodes; anything else decodes to a
// bubble so an unknown instruction can never write memory or registers.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OPCODE_BITS-1:0] i_opcode,
  output ctrl_bundle_t           o_ctrl,
  output logic                   o_valid
);

  // Decode table; unspecified fields are driven 0 rather than left floating
  always_comb begin
    o_ctrl  = BUBBLE;
    o_valid = 1'b0;
    case (i_opcode)
      RTYPE: begin
        o_ctrl.ex  = 4'b1100;
        o_ctrl.m   = 3'b000;
        o_ctrl.wb  = 2'b10;
        o_valid    = 1'b1;
      end
      LW: begin
        o_ctrl.ex  = 4'b0001;
        o_ctrl.m   = 3'b010;
        o_ctrl.wb  = 2'b11;
        o_valid    = 1'b1;
      end
      SW: begin
        o_ctrl.ex  = 4'b0001;
        o_ctrl.m   = 3'b001;
        o_ctrl.wb  = 2'b00;
        o_valid    = 1'b1;
      end
      BEQ: begin
        o_ctrl.ex  = 4'b0010;
        o_ctrl.m   = 3'b100;
        o_ctrl.wb  = 2'b00;
        o_valid    = 1'b1;
      end
      NOP: begin
        o_ctrl     = BUBBLE;
        o_valid    = 1'b1;
      end
      default: begin
        o_ctrl     = BUBBLE;
        o_valid    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the 5-stage MIPS datapath.
// Decodes the ID opcode, carries the control bundles through the ID/EX,
// EX/MEM and MEM/WB registers, inserts a bubble on a load-use hazard and
// squashes ID/EX and EX/MEM on a taken branch (flush).
// Build option: define CTRL_PIPE_ILLEGAL_TRAP_EN to make `illegal` a sticky
// flag for unrecognised opcodes; otherwise `illegal` is tied low.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_BITS,
  parameter int REG_W    = REG_BITS,
  parameter int EX_W     = EX_BITS,
  parameter int M_W      = M_BITS,
  parameter int WB_W     = WB_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                flush,
  output logic [EX_W-1:0]     idex_ex,
  output logic [REG_W-1:0]    idex_rt,
  output logic [M_W-1:0]      exmem_m,
  output logic [WB_W-1:0]     memwb_wb,
  output logic                stall,
  output logic                illegal
);

  ctrl_bundle_t     w_dec;
  logic             w_valid;
  logic             w_hazard;
  logic             w_bubble_id;

  logic [EX_W-1:0]  r_idex_ex;
  logic [M_W-1:0]   r_idex_m;
  logic [WB_W-1:0]  r_idex_wb;
  logic [REG_W-1:0] r_idex_rt;
  logic [M_W-1:0]   r_exmem_m;
  logic [WB_W-1:0]  r_exmem_wb;
  logic [WB_W-1:0]  r_memwb_wb;

  ctrl_decode u_decode (
    .i_opcode (opcode),
    .o_ctrl   (w_dec),
    .o_valid  (w_valid)
  );

  // A load in EX whose destination is read by the instruction in ID must
  // wait one cycle. $zero is hardwired, so rt==0 never creates a dependency.
  assign w_hazard = r_idex_m[MEMREAD_IDX]
                  & (r_idex_rt != '0)
                  & ((r_idex_rt == id_rs) | (r_idex_rt == id_rt));

  // A flush kills the instruction in ID anyway, so it overrides the stall
  assign stall       = w_hazard & ~flush;
  assign w_bubble_id = stall | flush;

  // Stage registers: ID/EX takes the decode or a bubble, EX/MEM is squashed
  // on flush, MEM/WB always advances (the instruction there is already past
  // the branch and must complete).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex_ex  <= BUBBLE_EX;
      r_idex_m   <= BUBBLE_M;
      r_idex_wb  <= BUBBLE_WB;
      r_idex_rt  <= '0;
      r_exmem_m  <= BUBBLE_M;
      r_exmem_wb <= BUBBLE_WB;
      r_memwb_wb <= BUBBLE_WB;
    end else begin
      if (w_bubble_id) begin
        r_idex_ex <= BUBBLE_EX;
        r_idex_m  <= BUBBLE_M;
        r_idex_wb <= BUBBLE_WB;
        r_idex_rt <= '0;
      end else begin
        r_idex_ex <= w_dec.ex;
        r_idex_m  <= w_dec.m;
        r_idex_wb <= w_dec.wb;
        r_idex_rt <= id_rt;
      end

      if (flush) begin
        r_exmem_m  <= BUBBLE_M;
        r_exmem_wb <= BUBBLE_WB;
      end else begin
        r_exmem_m  <= r_idex_m;
        r_exmem_wb <= r_idex_wb;
      end

      r_memwb_wb <= r_exmem_wb;
    end
  end

  assign idex_ex  = r_idex_ex;
  assign idex_rt  = r_idex_rt;
  assign exmem_m  = r_exmem_m;
  assign memwb_wb = r_memwb_wb;

`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky trap flag; an opcode sitting in ID during a stall or flush is not
  // being issued, so it cannot raise the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (!w_valid && !w_bubble_id) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  logic w_unused_valid;

  // Unknown opcodes are still bubbled by the decoder; the flag itself is off
  assign w_unused_valid = w_valid;
  assign illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: self-checking bench for ctrl_pipe.
// Directed table of cycle-by-cycle vectors, a hand-written illegal-opcode
// sequence, then randomized traffic against an instruction-level model.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       flush;
  logic [3:0] idex_ex;
  logic [4:0] idex_rt;
  logic [2:0] exmem_m;
  logic [1:0] memwb_wb;
  logic       stall;
  logic       illegal;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .flush    (flush),
    .idex_ex  (idex_ex),
    .idex_rt  (idex_rt),
    .exmem_m  (exmem_m),
    .memwb_wb (memwb_wb),
    .stall    (stall),
    .illegal  (illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl);
    rst    = r;
    opcode = op;
    id_rs  = rs;
    id_rt  = rt;
    flush  = fl;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors; expected outputs are those visible during that row
  typedef struct {
    logic       r;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       fl;
    logic       chk;
    logic [3:0] ex;
    logic [4:0] xrt;
    logic [2:0] m;
    logic [1:0] wb;
    logic       st;
  } vec_t;

  localparam logic [5:0] OR  = 6'b000000;
  localparam logic [5:0] OLW = 6'b100011;
  localparam logic [5:0] ONP = 6'b100000;
  localparam logic [5:0] OBAD = 6'b111111;

  vec_t vecs [18];

  // Instruction-level reference: each stage holds the instruction itself
  typedef struct {
    logic [5:0] op;
    logic [4:0] rt;
  } instr_t;

  instr_t pipe [3];
  logic   m_ill;

  // Control word {valid, EX, M, WB} of an instruction, straight from the table
  function automatic logic [9:0] spec_ctrl(input logic [5:0] op);
    case (op)
      6'b000000: return {1'b1, 4'b1100, 3'b000, 2'b10};
      6'b100011: return {1'b1, 4'b0001, 3'b010, 2'b11};
      6'b101011: return {1'b1, 4'b0001, 3'b001, 2'b00};
      6'b000100: return {1'b1, 4'b0010, 3'b100, 2'b00};
      6'b100000: return {1'b1, 9'b0};
      default:   return 10'b0;
    endcase
  endfunction

  function automatic instr_t bubble_instr();
    instr_t b;
    b.op = 6'b100000;
    b.rt = 5'd0;
    return b;
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return op == 6'b100011;
  endfunction

  initial begin
    logic [9:0] c;
    logic       exp_st;
    logic [5:0] op;
    instr_t     nw;

    vecs[0]  = '{1'b1, OR,  5'd0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0, 3'b000, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, OR,  5'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, OR,  5'd1, 5'd2, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, ONP, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1100, 5'd2, 3'b000, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, ONP, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, ONP, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b10, 1'b0};
    vecs[6]  = '{1'b0, OLW, 5'd1, 5'd5, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b00, 1'b0};
    vecs[7]  = '{1'b0, OR,  5'd5, 5'd3, 1'b0, 1'b1, 4'b0001, 5'd5, 3'b000, 2'b00, 1'b1};
    vecs[8]  = '{1'b0, OR,  5'd5, 5'd3, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b010, 2'b00, 1'b0};
    vecs[9]  = '{1'b0, ONP, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1100, 5'd3, 3'b000, 2'b11, 1'b0};
    vecs[10] = '{1'b0, OLW, 5'd1, 5'd0, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b00, 1'b0};
    vecs[11] = '{1'b0, OR,  5'd0, 5'd0, 1'b0, 1'b1, 4'b0001, 5'd0, 3'b000, 2'b10, 1'b0};
    vecs[12] = '{1'b0, OLW, 5'd1, 5'd5, 1'b0, 1'b1, 4'b1100, 5'd0, 3'b010, 2'b00, 1'b0};
    vecs[13] = '{1'b0, OR,  5'd5, 5'd3, 1'b1, 1'b1, 4'b0001, 5'd5, 3'b000, 2'b11, 1'b0};
    vecs[14] = '{1'b0, ONP, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b10, 1'b0};
    vecs[15] = '{1'b0, OLW, 5'd1, 5'd5, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b00, 1'b0};
    vecs[16] = '{1'b1, OR,  5'd5, 5'd3, 1'b0, 1'b1, 4'b0001, 5'd5, 3'b000, 2'b00, 1'b1};
    vecs[17] = '{1'b0, ONP, 5'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 5'd0, 3'b000, 2'b00, 1'b0};

    drive(1'b1, ONP, 5'd0, 5'd0, 1'b0);
    #1;

    // Directed table: reset, latency, load-use, $zero, flush vs stall, reset mid-stall
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].r, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].fl);
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("row%0d_idex_ex", i),  32'(idex_ex),  32'(vecs[i].ex));
        check($sformatf("row%0d_idex_rt", i),  32'(idex_rt),  32'(vecs[i].xrt));
        check($sformatf("row%0d_exmem_m", i),  32'(exmem_m),  32'(vecs[i].m));
        check($sformatf("row%0d_memwb_wb", i), 32'(memwb_wb), 32'(vecs[i].wb));
        check($sformatf("row%0d_stall", i),    32'(stall),    32'(vecs[i].st));
        check($sformatf("row%0d_illegal", i),  32'(illegal),  32'd0);
      end
      $display("vec %0d rst=%0b op=%b rs=%0d rt=%0d fl=%0b -> ex=%b rt=%0d m=%b wb=%b st=%0b",
               i, vecs[i].r, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].fl,
               idex_ex, idex_rt, exmem_m, memwb_wb, stall);
      next_edge();
    end

    // Illegal opcode ignored while stalled and while flushed
    drive(1'b1, ONP, 5'd0, 5'd0, 1'b0); next_edge();
    drive(1'b0, OLW, 5'd1, 5'd5, 1'b0); next_edge();
    drive(1'b0, OBAD, 5'd5, 5'd0, 1'b0);
    @(negedge clk);
    check("ill_stall_active", 32'(stall), 32'd1);
    next_edge();
    drive(1'b0, OBAD, 5'd0, 5'd0, 1'b1); next_edge();
    drive(1'b0, ONP, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("ill_ignored_stall_flush", 32'(illegal), 32'd0);
    $display("ill seq: stalled/flushed bad opcode -> illegal=%0b", illegal);
    next_edge();

    // Illegal opcode issued normally: bubble and (with trap) sticky flag
    drive(1'b0, OBAD, 5'd0, 5'd7, 1'b0); next_edge();
    drive(1'b0, ONP, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("ill_set", 32'(illegal), 32'(TRAP));
    check("ill_bubble_ex", 32'(idex_ex), 32'd0);
    $display("ill seq: bad opcode issued -> illegal=%0b ex=%b", illegal, idex_ex);
    for (int k = 0; k < 3; k++) begin
      next_edge();
      @(negedge clk);
      check($sformatf("ill_sticky%0d", k), 32'(illegal), 32'(TRAP));
    end
    next_edge();
    drive(1'b1, ONP, 5'd0, 5'd0, 1'b0); next_edge();
    drive(1'b0, ONP, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("ill_cleared_by_rst", 32'(illegal), 32'd0);
    $display("ill seq: after rst -> illegal=%0b", illegal);
    next_edge();

    // Randomized traffic against the instruction-level model
    drive(1'b1, ONP, 5'd0, 5'd0, 1'b0); next_edge();
    for (int s = 0; s < 3; s++) pipe[s] = bubble_instr();
    m_ill = 1'b0;

    for (int n = 0; n < 400; n++) begin
      logic       r, fl;
      logic [4:0] rs, rt;
      case ($urandom_range(0, 5))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b100000;
        default: op = 6'($urandom);
      endcase
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      fl = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 39) == 0);
      drive(r, op, rs, rt, fl);
      @(negedge clk);

      exp_st = is_load(pipe[0].op) && (pipe[0].rt != 0)
               && (pipe[0].rt == rs || pipe[0].rt == rt) && !fl;
      c = spec_ctrl(pipe[0].op);
      check("rnd_idex_ex", 32'(idex_ex), 32'(c[8:5]));
      check("rnd_idex_rt", 32'(idex_rt), 32'(pipe[0].rt));
      c = spec_ctrl(pipe[1].op);
      check("rnd_exmem_m", 32'(exmem_m), 32'(c[4:2]));
      c = spec_ctrl(pipe[2].op);
      check("rnd_memwb_wb", 32'(memwb_wb), 32'(c[1:0]));
      check("rnd_stall", 32'(stall), 32'(exp_st));
      check("rnd_illegal", 32'(illegal), 32'(m_ill));
      $display("rnd %0d rst=%0b op=%b rs=%0d rt=%0d fl=%0b -> ex=%b m=%b wb=%b st=%0b ill=%0b",
               n, r, op, rs, rt, fl, idex_ex, exmem_m, memwb_wb, stall, illegal);

      // Advance the model one cycle
      if (r) begin
        for (int s = 0; s < 3; s++) pipe[s] = bubble_instr();
        m_ill = 1'b0;
      end else begin
        c = spec_ctrl(op);
        if (TRAP && !c[9] && !fl && !exp_st) m_ill = 1'b1;
        nw.op = op;
        nw.rt = rt;
        if (fl || exp_st) nw = bubble_instr();
        pipe[2] = pipe[1];
        pipe[1] = fl ? bubble_instr() : pipe[0];
        pipe[0] = nw;
      end
      next_edge();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
